// File: rtl/axil_protocol_monitor.sv
// -----------------------------------------------------------------------------
// axil_protocol_monitor
//
// AXI-Lite slave-side protocol checker. It sits between a register station's
// slave port and its response logic and provides two things:
//
//   * Combinational, zero-latency per-request error flags for SLVERR
//     generation: misaligned or out-of-range AW/AR addresses, and W beats
//     with an all-zero strobe. These flags are gated by ERR_RESP_EN.
//
//   * An always-on sequential monitor on all five channels that reports
//     events into a sticky status word, a saturating error counter and an
//     interrupt. The events are:
//       - content errors logged at handshake (AW addr, W strobe, AR addr),
//       - handshake-stability violations (valid dropped or payload changed
//         while stalled),
//       - stall timeouts.
//
// Sticky bit map:
//   0 aw_addr_err  1 w_strb_zero  2 ar_addr_err
//   3 aw_unstable  4 w_unstable   5 ar_unstable  6 b_unstable  7 r_unstable
//   8 timeout
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   s_axi_aw*            write address channel (observed only)
//   s_axi_w*             write data channel    (observed only)
//   s_axi_b*             write response channel (observed only)
//   s_axi_ar*            read address channel  (observed only)
//   s_axi_r*             read data channel     (observed only)
//   clear_i              one-cycle pulse clearing sticky_o / err_count_o
//   err_awrite_o         AW request misaligned or out of range (comb)
//   err_write_o          W strobe all zero (comb)
//   err_read_o           AR request misaligned or out of range (comb)
//   sticky_o             sticky event bits (registered)
//   err_count_o          saturating count of cycles with any event
//   irq_o                OR of sticky_o (registered)
// -----------------------------------------------------------------------------
module axil_protocol_monitor #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter bit                    ERR_RESP_EN    = 1'b0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT     = '0,
  parameter int                    TIMEOUT_CYCLES = 256,
  parameter int                    CNT_WIDTH      = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_awvalid,
  input  logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  input  logic                    s_axi_wready,
  input  logic [1:0]              s_axi_bresp,
  input  logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]              s_axi_arprot,
  input  logic                    s_axi_arvalid,
  input  logic                    s_axi_arready,
  input  logic [DATA_WIDTH-1:0]   s_axi_rdata,
  input  logic [1:0]              s_axi_rresp,
  input  logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  input  logic                    clear_i,
  output logic                    err_awrite_o,
  output logic                    err_write_o,
  output logic                    err_read_o,
  output logic [8:0]              sticky_o,
  output logic [CNT_WIDTH-1:0]    err_count_o,
  output logic                    irq_o
);

  localparam int ALIGN = $clog2(DATA_WIDTH / 8);

  // Widest per-channel payload; every channel is zero-extended to this.
  localparam int AW_PW = ADDR_WIDTH + 3;
  localparam int W_PW  = DATA_WIDTH + DATA_WIDTH / 8;
  localparam int R_PW  = DATA_WIDTH + 2;
  localparam int PW    = (AW_PW > W_PW) ? ((AW_PW > R_PW) ? AW_PW : R_PW)
                                        : ((W_PW  > R_PW) ? W_PW  : R_PW);

  // A disabled timeout still needs a legal 1-bit counter.
  localparam int TCW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TCW-1:0] TMAX  = TCW'(TIMEOUT_CYCLES);
  localparam logic [TCW-1:0] TLAST = (TIMEOUT_CYCLES > 0) ? TCW'(TIMEOUT_CYCLES - 1) : '0;

  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    logic mis;
    logic oor;
    mis = |a[ALIGN-1:0];
    oor = (ADDR_LIMIT != '0) && (a >= ADDR_LIMIT);
    return mis | oor;
  endfunction

  // Request classification, independent of handshake.
  logic aw_bad, w_bad, ar_bad;
  assign aw_bad = s_axi_awvalid & addr_err(s_axi_awaddr);
  assign w_bad  = s_axi_wvalid & (s_axi_wstrb == '0);
  assign ar_bad = s_axi_arvalid & addr_err(s_axi_araddr);

  assign err_awrite_o = ERR_RESP_EN ? aw_bad : 1'b0;
  assign err_write_o  = ERR_RESP_EN ? w_bad  : 1'b0;
  assign err_read_o   = ERR_RESP_EN ? ar_bad : 1'b0;

  // Channel index: 0 AW, 1 W, 2 AR, 3 B, 4 R (matches sticky bits 3..7).
  logic [4:0]    vld, rdy;
  logic [PW-1:0] pay [5];

  assign vld = {s_axi_rvalid, s_axi_bvalid, s_axi_arvalid, s_axi_wvalid, s_axi_awvalid};
  assign rdy = {s_axi_rready, s_axi_bready, s_axi_arready, s_axi_wready, s_axi_awready};

  always_comb begin
    pay[0] = PW'({s_axi_awprot, s_axi_awaddr});
    pay[1] = PW'({s_axi_wstrb, s_axi_wdata});
    pay[2] = PW'({s_axi_arprot, s_axi_araddr});
    pay[3] = PW'(s_axi_bresp);
    pay[4] = PW'({s_axi_rresp, s_axi_rdata});
  end

  logic [4:0]     stalled_q;
  logic [PW-1:0]  pay_q [5];
  logic [TCW-1:0] stall_cnt_q [5];
  logic [TCW-1:0] stall_cnt_d [5];
  logic [4:0]     stall, unstable, to_hit;

  // The counter parks at TMAX for the rest of a stall, so the TLAST match
  // that fires the timeout can only happen once until the stall ends.
  always_comb begin
    stall    = '0;
    unstable = '0;
    to_hit   = '0;
    for (int i = 0; i < 5; i++) begin
      stall[i]    = vld[i] & ~rdy[i];
      unstable[i] = stalled_q[i] & (~vld[i] | (pay[i] != pay_q[i]));
      to_hit[i]   = (TIMEOUT_CYCLES != 0) && stall[i] && (stall_cnt_q[i] == TLAST);
      if (!stall[i]) begin
        stall_cnt_d[i] = '0;
      end else if (stall_cnt_q[i] == TMAX) begin
        stall_cnt_d[i] = stall_cnt_q[i];
      end else begin
        stall_cnt_d[i] = stall_cnt_q[i] + TCW'(1);
      end
    end
  end

  logic [8:0] events;
  logic       any_event;

  // Content errors only count at acceptance, so a stalled bad request
  // is logged exactly once.
  assign events = {|to_hit,
                   unstable,
                   ar_bad & s_axi_arready,
                   w_bad  & s_axi_wready,
                   aw_bad & s_axi_awready};
  assign any_event = |events;

  logic [8:0]           sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 irq_q;

  // Clear loads the current cycle's events rather than zero, so an event
  // coinciding with clear is never dropped.
  always_comb begin
    sticky_d = clear_i ? events : (sticky_q | events);
    if (clear_i) begin
      cnt_d = CNT_WIDTH'(any_event);
    end else if (any_event && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Payload capture: data only, valid qualified by stalled_q.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 5; i++) begin
      pay_q[i] <= pay[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stalled_q <= '0;
      for (int i = 0; i < 5; i++) begin
        stall_cnt_q[i] <= '0;
      end
      sticky_q <= '0;
      cnt_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      stalled_q <= stall;
      for (int i = 0; i < 5; i++) begin
        stall_cnt_q[i] <= stall_cnt_d[i];
      end
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      irq_q    <= |sticky_d;
    end
  end

  assign sticky_o    = sticky_q;
  assign err_count_o = cnt_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_axil_protocol_monitor.sv
module tb_axil_protocol_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clear;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;

  logic        err_aw_a, err_w_a, err_ar_a, irq_a;
  logic [8:0]  sticky_a;
  logic [1:0]  cnt_a;
  logic        err_aw_b, err_w_b, err_ar_b, irq_b;
  logic [8:0]  sticky_b;
  logic [15:0] cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Config A: error responses on, range limit, short timeout, tiny counter.
  axil_protocol_monitor #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ERR_RESP_EN(1'b1),
    .ADDR_LIMIT(32'h8000), .TIMEOUT_CYCLES(4), .CNT_WIDTH(2)
  ) u_dut_a (
    .clk_i(clk), .rst_i(rst),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .clear_i(clear),
    .err_awrite_o(err_aw_a), .err_write_o(err_w_a), .err_read_o(err_ar_a),
    .sticky_o(sticky_a), .err_count_o(cnt_a), .irq_o(irq_a)
  );

  // Config B: error responses off, no range limit, no timeout, wide counter.
  axil_protocol_monitor #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ERR_RESP_EN(1'b0),
    .ADDR_LIMIT(32'h0), .TIMEOUT_CYCLES(0), .CNT_WIDTH(16)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .clear_i(clear),
    .err_awrite_o(err_aw_b), .err_write_o(err_w_b), .err_read_o(err_ar_b),
    .sticky_o(sticky_b), .err_count_o(cnt_b), .irq_o(irq_b)
  );

  // ---------------- reference model ----------------
  function automatic int to_of(input int c);   return (c == 0) ? 4 : 0; endfunction
  function automatic logic [31:0] lim_of(input int c); return (c == 0) ? 32'h8000 : 32'h0; endfunction
  function automatic int cmax_of(input int c); return (c == 0) ? 3 : 65535; endfunction

  function automatic logic addr_bad(input logic [31:0] a, input logic [31:0] lim);
    return (a % 4 != 0) || (lim != 0 && a >= lim);
  endfunction

  function automatic logic ch_valid(input int ch);
    case (ch)
      0: return awvalid; 1: return wvalid; 2: return arvalid; 3: return bvalid;
      default: return rvalid;
    endcase
  endfunction

  function automatic logic ch_ready(input int ch);
    case (ch)
      0: return awready; 1: return wready; 2: return arready; 3: return bready;
      default: return rready;
    endcase
  endfunction

  function automatic logic [63:0] ch_pay(input int ch);
    case (ch)
      0: return {29'b0, awprot, awaddr};
      1: return {28'b0, wstrb, wdata};
      2: return {29'b0, arprot, araddr};
      3: return {62'b0, bresp};
      default: return {30'b0, rresp, rdata};
    endcase
  endfunction

  // Last cycle's stall status / payload and length of the current stall run.
  logic        m_stall [5];
  logic [63:0] m_pay   [5];
  int          m_run   [5];
  logic [8:0]  m_sticky [2];
  int          m_cnt    [2];

  function automatic logic [8:0] m_events(input int c);
    logic [8:0] ev;
    ev = '0;
    ev[0] = awvalid && awready && addr_bad(awaddr, lim_of(c));
    ev[1] = wvalid && wready && (wstrb == 4'h0);
    ev[2] = arvalid && arready && addr_bad(araddr, lim_of(c));
    for (int ch = 0; ch < 5; ch++) begin
      if (m_stall[ch] && (!ch_valid(ch) || ch_pay(ch) != m_pay[ch])) ev[3 + ch] = 1'b1;
      if (to_of(c) > 0 && ch_valid(ch) && !ch_ready(ch) && m_run[ch] + 1 == to_of(c)) ev[8] = 1'b1;
    end
    return ev;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < 5; ch++) begin
        m_stall[ch] <= 1'b0;
        m_run[ch]   <= 0;
      end
      for (int c = 0; c < 2; c++) begin
        m_sticky[c] <= '0;
        m_cnt[c]    <= 0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (clear) begin
          m_sticky[c] <= m_events(c);
          m_cnt[c]    <= (m_events(c) != 0) ? 1 : 0;
        end else begin
          m_sticky[c] <= m_sticky[c] | m_events(c);
          if (m_events(c) != 0 && m_cnt[c] < cmax_of(c)) m_cnt[c] <= m_cnt[c] + 1;
        end
      end
      for (int ch = 0; ch < 5; ch++) begin
        m_stall[ch] <= ch_valid(ch) && !ch_ready(ch);
        m_pay[ch]   <= ch_pay(ch);
        m_run[ch]   <= (ch_valid(ch) && !ch_ready(ch)) ? m_run[ch] + 1 : 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_idle();
    clear = 0;
    awvalid = 0; awready = 0; wvalid = 0; wready = 0; bvalid = 0; bready = 0;
    arvalid = 0; arready = 0; rvalid = 0; rready = 0;
  endtask

  task automatic do_clear();
    set_idle();
    @(negedge clk);
    clear = 1;
    @(negedge clk);
    clear = 0;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h4;
      2: return 32'h1002;
      3: return 32'h8000;
      4: return 32'h7ffc;
      default: return 32'h10001;
    endcase
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    set_idle();
    rst = 1;
    repeat (2) @(negedge clk);
    n_checks++; if (sticky_a !== 9'h0) begin n_fail++; $display("FAIL reset_sticky_a got=%h exp=000", sticky_a); end
    n_checks++; if (cnt_a !== 2'd0) begin n_fail++; $display("FAIL reset_cnt_a got=%0d exp=0", cnt_a); end
    n_checks++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL reset_irq_a got=%b exp=0", irq_a); end
    n_checks++; if (sticky_b !== 9'h0 || cnt_b !== 16'd0 || irq_b !== 1'b0) begin
      n_fail++; $display("FAIL reset_b got sticky=%h cnt=%0d irq=%b exp all 0", sticky_b, cnt_b, irq_b); end
    rst = 0;
  endtask

  task automatic test_aw_content();
    do_clear();
    awvalid = 1; awready = 1; awaddr = 32'h1002; awprot = 3'd0;
    #1;
    n_checks++; if (err_aw_a !== 1'b1) begin n_fail++; $display("FAIL aw_comb_a got=%b exp=1", err_aw_a); end
    n_checks++; if (err_aw_b !== 1'b0) begin n_fail++; $display("FAIL aw_comb_b_disabled got=%b exp=0", err_aw_b); end
    @(negedge clk);
    set_idle();
    n_checks++; if (sticky_a !== 9'h001) begin n_fail++; $display("FAIL aw_sticky got=%h exp=001", sticky_a); end
    n_checks++; if (cnt_a !== 2'd1) begin n_fail++; $display("FAIL aw_cnt got=%0d exp=1", cnt_a); end
    n_checks++; if (irq_a !== 1'b1) begin n_fail++; $display("FAIL aw_irq got=%b exp=1", irq_a); end
    n_checks++; if (sticky_b[0] !== 1'b1) begin n_fail++; $display("FAIL aw_sticky_b0 got=%b exp=1", sticky_b[0]); end
  endtask

  task automatic test_w_stall();
    do_clear();
    wvalid = 1; wready = 0; wstrb = 4'h0; wdata = $urandom;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (err_w_a !== 1'b1) begin n_fail++; $display("FAIL w_comb_stall%0d got=%b exp=1", k, err_w_a); end
      @(negedge clk);
      n_checks++; if (sticky_a !== 9'h0 || cnt_a !== 2'd0) begin
        n_fail++; $display("FAIL w_stall%0d got sticky=%h cnt=%0d exp 000/0", k, sticky_a, cnt_a); end
    end
    wready = 1;
    #1;
    n_checks++; if (err_w_a !== 1'b1) begin n_fail++; $display("FAIL w_comb_hs got=%b exp=1", err_w_a); end
    @(negedge clk);
    set_idle();
    n_checks++; if (sticky_a !== 9'h002) begin n_fail++; $display("FAIL w_sticky got=%h exp=002", sticky_a); end
    n_checks++; if (cnt_a !== 2'd1) begin n_fail++; $display("FAIL w_cnt got=%0d exp=1", cnt_a); end
  endtask

  task automatic test_ar_unstable();
    do_clear();
    arvalid = 1; arready = 0; araddr = 32'h10; arprot = 3'd2;
    @(negedge clk);
    n_checks++; if (sticky_a !== 9'h0) begin n_fail++; $display("FAIL ar_pre got=%h exp=000", sticky_a); end
    araddr = 32'h14;
    @(negedge clk);
    n_checks++; if (sticky_a !== 9'h020) begin n_fail++; $display("FAIL ar_unstable got=%h exp=020", sticky_a); end
    n_checks++; if (cnt_a !== 2'd1) begin n_fail++; $display("FAIL ar_cnt got=%0d exp=1", cnt_a); end
    arready = 1;
    @(negedge clk);
    set_idle();
    n_checks++; if (cnt_a !== 2'd1) begin n_fail++; $display("FAIL ar_cnt_after_hs got=%0d exp=1", cnt_a); end
  endtask

  task automatic test_timeout();
    do_clear();
    bvalid = 1; bready = 0; bresp = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (sticky_a !== ((k >= 4) ? 9'h100 : 9'h000) || cnt_a !== ((k >= 4) ? 2'd1 : 2'd0)) begin
        n_fail++; $display("FAIL timeout_cyc%0d got sticky=%h cnt=%0d exp %h/%0d",
                           k, sticky_a, cnt_a, (k >= 4) ? 9'h100 : 9'h000, (k >= 4) ? 1 : 0);
      end
    end
    n_checks++; if (sticky_b !== 9'h0) begin n_fail++; $display("FAIL timeout_disabled_b got=%h exp=000", sticky_b); end
    bready = 1;
    @(negedge clk);
    set_idle();
    n_checks++; if (cnt_a !== 2'd1) begin n_fail++; $display("FAIL timeout_cnt_end got=%0d exp=1", cnt_a); end
  endtask

  task automatic test_clear_race();
    do_clear();
    awvalid = 1; awready = 0; awaddr = 32'h200; awprot = 3'd0;
    @(negedge clk);
    awaddr = 32'h201; awready = 1;
    @(negedge clk);
    set_idle();
    n_checks++; if (sticky_a !== 9'h009 || cnt_a !== 2'd1) begin
      n_fail++; $display("FAIL race_setup got sticky=%h cnt=%0d exp 009/1", sticky_a, cnt_a); end
    rvalid = 1; rready = 0; rdata = $urandom; rresp = 2'b00;
    @(negedge clk);
    rvalid = 0; clear = 1;
    @(negedge clk);
    clear = 0;
    n_checks++; if (sticky_a !== 9'h080) begin n_fail++; $display("FAIL race_sticky got=%h exp=080", sticky_a); end
    n_checks++; if (cnt_a !== 2'd1 || irq_a !== 1'b1) begin
      n_fail++; $display("FAIL race_cnt_irq got cnt=%0d irq=%b exp 1/1", cnt_a, irq_a); end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_sat [5];
    exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_clear();
    for (int k = 0; k < 5; k++) begin
      awvalid = 1; awready = 1; awaddr = 32'h1001;
      @(negedge clk);
      set_idle();
      n_checks++; if (cnt_a !== exp_sat[k]) begin n_fail++; $display("FAIL sat_a_%0d got=%0d exp=%0d", k, cnt_a, exp_sat[k]); end
      n_checks++; if (cnt_b !== 16'(k + 1)) begin n_fail++; $display("FAIL sat_b_%0d got=%0d exp=%0d", k, cnt_b, k + 1); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_stall();
    set_idle();
    arvalid = 1; arready = 0; araddr = 32'h40;
    repeat (2) @(negedge clk);
    rst = 1; araddr = 32'h44;
    @(negedge clk);
    rst = 0;
    n_checks++; if (sticky_a !== 9'h0 || cnt_a !== 2'd0 || irq_a !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid got sticky=%h cnt=%0d irq=%b exp 0", sticky_a, cnt_a, irq_a); end
    arvalid = 0;
    @(negedge clk);
    n_checks++; if (sticky_a !== 9'h0 || sticky_b !== 9'h0) begin
      n_fail++; $display("FAIL rst_first_cycle got a=%h b=%h exp 000", sticky_a, sticky_b); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n_checks++;
      if (sticky_a !== m_sticky[0] || cnt_a !== 2'(m_cnt[0]) || irq_a !== (|m_sticky[0])) begin
        n_fail++; $display("FAIL rand_a cyc%0d got sticky=%h cnt=%0d irq=%b exp %h/%0d/%b",
                           i, sticky_a, cnt_a, irq_a, m_sticky[0], m_cnt[0], |m_sticky[0]);
      end
      n_checks++;
      if (sticky_b !== m_sticky[1] || cnt_b !== 16'(m_cnt[1]) || irq_b !== (|m_sticky[1])) begin
        n_fail++; $display("FAIL rand_b cyc%0d got sticky=%h cnt=%0d irq=%b exp %h/%0d/%b",
                           i, sticky_b, cnt_b, irq_b, m_sticky[1], m_cnt[1], |m_sticky[1]);
      end
      rst   = ($urandom_range(0, 99) == 0);
      clear = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) begin awvalid = $urandom; awaddr = pick_addr(); awprot = $urandom; end
      if ($urandom_range(0, 3) == 0) begin
        wvalid = $urandom; wdata = $urandom_range(0, 3);
        wstrb = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      end
      if ($urandom_range(0, 3) == 0) begin arvalid = $urandom; araddr = pick_addr(); arprot = $urandom; end
      if ($urandom_range(0, 3) == 0) begin bvalid = $urandom; bresp = $urandom; end
      if ($urandom_range(0, 3) == 0) begin rvalid = $urandom; rdata = $urandom_range(0, 3); rresp = $urandom; end
      awready = ($urandom_range(0, 2) == 0);
      wready  = ($urandom_range(0, 2) == 0);
      arready = ($urandom_range(0, 2) == 0);
      bready  = ($urandom_range(0, 2) == 0);
      rready  = ($urandom_range(0, 2) == 0);
      #1;
      n_checks++;
      if (err_aw_a !== (awvalid && addr_bad(awaddr, 32'h8000)) ||
          err_w_a  !== (wvalid && wstrb == 4'h0) ||
          err_ar_a !== (arvalid && addr_bad(araddr, 32'h8000))) begin
        n_fail++; $display("FAIL rand_comb_a cyc%0d got aw=%b w=%b ar=%b", i, err_aw_a, err_w_a, err_ar_a);
      end
      n_checks++;
      if ({err_aw_b, err_w_b, err_ar_b} !== 3'b000) begin
        n_fail++; $display("FAIL rand_comb_b cyc%0d got %b%b%b exp 000", i, err_aw_b, err_w_b, err_ar_b);
      end
    end
    rst = 0;
    set_idle();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1; set_idle();
    awaddr = 0; awprot = 0; wdata = 0; wstrb = 4'hf; bresp = 0;
    araddr = 0; arprot = 0; rdata = 0; rresp = 0;
    test_reset();
    test_aw_content();
    test_w_stall();
    test_ar_unstable();
    test_timeout();
    test_clear_race();
    test_saturate();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
